com_tick_scheduler: RTL and testbench
=====================================

// Module: com_tick_scheduler
// PURPOSE
//  Consumes the periodic tick from the communication interval timer and turns it into
//  NUM_CH independent transmit-slot requests, each with a programmable period in ticks.
//  Per channel: a one-cycle due_pulse to the TX/DMA engine, a sticky pending flag,
//  a sticky overrun flag, and a maskable aggregated irq.
//  Avalon-MM slave on the Nios II system bus: 16-bit data, 3-bit word address.
// PARAMETERS
//  NUM_CH    4   number of scheduled channels (1..8)
//  PERIOD_W  8   per-channel period/countdown width in bits (1..16)
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         reset, asynchronous, active-low
//  tick_in     in   1         timer timeout output; each rising edge is one tick
//  address     in   3         Avalon word address
//  chipselect  in   1         Avalon chip select
//  write_n     in   1         Avalon write strobe, active-low
//  writedata   in   16        Avalon write data
//  readdata    out  16        Avalon read data, registered
//  due_pulse   out  NUM_CH    one-cycle slot request per channel
//  irq         out  1         |(pending & irq_mask)
// BEHAVIOUR
//  Reset: readdata=0, due_pulse=0, irq=0, pending=0, overrun=0, ch_en=0, irq_mask=0,
//   sel=0, all periods=0, all countdowns=0, tick_q=0, tick_cnt=0.
//  Tick detect: tick_q <= tick_in each cycle; tick_evt = tick_in & ~tick_q.
//   A level held high counts once.
//  Write decode: wr(a) = chipselect & ~write_n & (address==a). Reads have no side effects.
//  Register map:
//   0 STATUS   R: [NUM_CH-1:0]=pending, [8+NUM_CH-1:8]=overrun.
//              W: 1 clears the matching pending/overrun bit; 0 leaves it unchanged.
//   1 CONTROL  RW: [NUM_CH-1:0]=ch_en, [8+NUM_CH-1:8]=irq_mask.
//   2 SEL      RW: [2:0]=channel index; index >= NUM_CH makes PERIOD read 0 and ignores writes.
//   3 PERIOD   RW: period[sel] in [PERIOD_W-1:0]; channel fires every period+1 ticks.
//   4 TICKCNT  R: free-running 16-bit count of tick_evt, wraps 0xFFFF->0.
//   other      R: 0.
//  readdata <= mux(address) on every clock, independent of chipselect; read latency is 1 cycle.
//  Per channel i, evaluated at each clock edge in this priority:
//   1. Reload: countdown <= period when any of:
//      - PERIOD is written with sel==i (period and countdown both take writedata);
//      - ch_en[i] rises 0->1.
//      A tick in the same cycle is ignored for that channel.
//   2. Otherwise, if ch_en[i] & tick_evt:
//      - countdown==0: countdown <= period, fire_i=1;
//      - otherwise: countdown <= countdown-1.
//   3. ch_en[i]==0: countdown holds and no fire occurs. pending and overrun are kept.
//  fire_i effects, registered in the same edge, visible the cycle after tick_evt:
//   due_pulse[i]=1 for exactly 1 cycle; pending[i] <= 1.
//   overrun[i] <= 1 if pending[i] was already 1 before this edge.
//  Simultaneous STATUS clear and fire on the same edge: fire wins.
//   pending stays 1 and overrun is not set by that fire.
//   An overrun clear together with a fire that overruns: set wins.
//  period==0: fires on every tick. Countdown wraps only through reload, never by underflow.
//  irq is combinational from registered pending & irq_mask; no added latency.
//  Reset mid-operation clears everything immediately (async). No pulse is emitted during reset.
// STRUCTURE
//  Shared package com_sched_pkg:
//   - address constants: STATUS=0, CONTROL=1, SEL=2, PERIOD=3, TICKCNT=4;
//   - bit offsets: OVR_LSB=8, MASK_LSB=8.
//  Sub-module com_sched_channel, instantiated NUM_CH times (generate):
//   - holds period, countdown, en_q, pending, overrun;
//   - inputs: tick_evt, en, load/wdata, clr_pend, clr_ovr;
//   - outputs: due_pulse, pending, overrun, period.
//  Top level holds the bus decode, tick detect, TICKCNT, read mux and irq OR-reduce.
// TESTING
//  1. Basic period: PERIOD[0]=2, CONTROL=0x0101, 9 ticks -> due_pulse[0] after ticks 3, 6, 9;
//     pending[0]=1; irq=1; STATUS write 0x0001 -> irq=0 next cycle.
//  2. Overrun: PERIOD[1]=0, ch1 enabled, 2 ticks with no clear -> STATUS reads 0x0202.
//     Write 0x0202 -> reads 0x0000.
//  3. Clear/fire race: STATUS write 0x0001 on the same edge as a ch0 fire ->
//     pending[0] stays 1, overrun[0] stays 0, due_pulse[0] asserted.
//  4. tick_in held high for 10 cycles -> TICKCNT +1 only.
//     PERIOD written on a tick edge -> countdown=new value, no decrement on that edge.
//  5. Disable/enable: disable ch0 mid-count -> no pulses and countdown frozen.
//     Re-enable -> countdown reloaded and first fire after period+1 ticks.
//     SEL=5 -> PERIOD reads 0 and writes are ignored.
//  6. Async reset asserted between ticks mid-count -> all outputs 0 at once.
//     After release, no fires until ch_en is written; TICKCNT reads 0.

Source files
------------

// File: rtl/com_sched_pkg.sv
// -----------------------------------------------------------------------------
// com_sched_pkg
// Shared definitions for the communication tick scheduler:
//   - Avalon word addresses of the register map
//   - bit offsets of the upper half-word fields (overrun flags, irq mask)
//   - bus widths
// -----------------------------------------------------------------------------
package com_sched_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int SEL_W    = 3;

  // Register map (word addresses)
  localparam logic [ADDR_W-1:0] STATUS  = 3'd0;
  localparam logic [ADDR_W-1:0] CONTROL = 3'd1;
  localparam logic [ADDR_W-1:0] SEL     = 3'd2;
  localparam logic [ADDR_W-1:0] PERIOD  = 3'd3;
  localparam logic [ADDR_W-1:0] TICKCNT = 3'd4;

  // Upper half-word field offsets
  localparam int OVR_LSB  = 8;
  localparam int MASK_LSB = 8;

endpackage

// File: rtl/com_sched_channel.sv
// -----------------------------------------------------------------------------
// com_sched_channel
// One scheduled transmit-slot channel. Counts ticks down from a programmable
// period and fires every period+1 ticks while enabled.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick_evt     : one-cycle tick event from the top-level edge detector
//   en           : channel enable (registered CONTROL bit)
//   load, wdata  : PERIOD write targeting this channel; loads period and countdown
//   clr_pend     : clear request for the pending flag
//   clr_ovr      : clear request for the overrun flag
//   due_pulse    : registered one-cycle slot request
//   pending      : sticky "slot due" flag
//   overrun      : sticky "slot fired while still pending" flag
//   period       : current programmed period (for read-back)
// -----------------------------------------------------------------------------
module com_sched_channel
  import com_sched_pkg::*;
#(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_evt,
  input  logic                en,
  input  logic                load,
  input  logic [PERIOD_W-1:0] wdata,
  input  logic                clr_pend,
  input  logic                clr_ovr,
  output logic                due_pulse,
  output logic                pending,
  output logic                overrun,
  output logic [PERIOD_W-1:0] period
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic                en_q;
  logic                due_q, due_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                fire_s;
  logic                en_rise_s;

  // Enable rising edge restarts the countdown from the programmed period.
  assign en_rise_s = en & ~en_q;

  // Countdown / fire decision: reload beats tick, tick only counts when enabled.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    fire_s   = 1'b0;
    if (load) begin
      period_d = wdata;
      count_d  = wdata;
    end else if (en_rise_s) begin
      count_d = period_q;
    end else if (en & tick_evt) begin
      if (count_q == {PERIOD_W{1'b0}}) begin
        count_d = period_q;
        fire_s  = 1'b1;
      end else begin
        count_d = count_q - PERIOD_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Status flags: a fire beats a same-edge clear; an overrun needs the pending
  // flag to survive this edge, so a fire racing a pending clear is not an overrun.
  always_comb begin
    due_d = fire_s;
    if (fire_s) begin
      pend_d = 1'b1;
    end else if (clr_pend) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (fire_s & pend_q & ~clr_pend) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= {PERIOD_W{1'b0}};
      count_q  <= {PERIOD_W{1'b0}};
      en_q     <= 1'b0;
      due_q    <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      en_q     <= en;
      due_q    <= due_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  assign due_pulse = due_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;
  assign period    = period_q;

endmodule

// File: rtl/com_tick_scheduler.sv
// -----------------------------------------------------------------------------
// com_tick_scheduler
// Turns the periodic communication-timer tick into NUM_CH independent transmit
// slot requests with programmable periods; Avalon-MM slave for configuration.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick_in      : timer timeout; each rising edge is one tick
//   address      : Avalon word address (3 bits)
//   chipselect   : Avalon chip select
//   write_n      : Avalon write strobe, active-low
//   writedata    : Avalon write data (16 bits)
//   readdata     : Avalon read data, registered, 1-cycle latency
//   due_pulse    : per-channel one-cycle slot request
//   irq          : OR of pending flags gated by the irq mask
// -----------------------------------------------------------------------------
module com_tick_scheduler
  import com_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [NUM_CH-1:0] due_pulse,
  output logic              irq
);

  logic                tick_q;
  logic                tick_evt_s;
  logic [DATA_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]   irq_mask_q, irq_mask_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;

  logic                wr_en_s;
  logic                wr_status_s;
  logic                wr_control_s;
  logic                wr_sel_s;
  logic                wr_period_s;

  logic [NUM_CH-1:0]   load_s;
  logic [NUM_CH-1:0]   clr_pend_s;
  logic [NUM_CH-1:0]   clr_ovr_s;
  logic [NUM_CH-1:0]   pending_s;
  logic [NUM_CH-1:0]   overrun_s;
  logic [NUM_CH-1:0]   due_s;
  logic [PERIOD_W-1:0] period_s [NUM_CH];

  // Upper writedata bits beyond the channel fields have no function.
  logic                unused_wdata_s;
  assign unused_wdata_s = ^writedata;

  // A level held high produces a single tick event.
  assign tick_evt_s = tick_in & ~tick_q;

  // Bus write decode; reads have no side effects.
  always_comb begin
    wr_en_s      = chipselect & ~write_n;
    wr_status_s  = wr_en_s & (address == STATUS);
    wr_control_s = wr_en_s & (address == CONTROL);
    wr_sel_s     = wr_en_s & (address == SEL);
    wr_period_s  = wr_en_s & (address == PERIOD);
    clr_pend_s   = {NUM_CH{wr_status_s}} & writedata[NUM_CH-1:0];
    clr_ovr_s    = {NUM_CH{wr_status_s}} & writedata[OVR_LSB +: NUM_CH];
  end

  // Next state of the configuration registers and the tick counter.
  always_comb begin
    if (wr_control_s) begin
      ch_en_d    = writedata[NUM_CH-1:0];
      irq_mask_d = writedata[MASK_LSB +: NUM_CH];
    end else begin
      ch_en_d    = ch_en_q;
      irq_mask_d = irq_mask_q;
    end
    if (wr_sel_s) begin
      sel_d = writedata[SEL_W-1:0];
    end else begin
      sel_d = sel_q;
    end
    if (tick_evt_s) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Read mux, sampled every clock regardless of chipselect.
  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      STATUS: begin
        readdata_d[NUM_CH-1:0]          = pending_s;
        readdata_d[OVR_LSB +: NUM_CH]   = overrun_s;
      end
      CONTROL: begin
        readdata_d[NUM_CH-1:0]          = ch_en_q;
        readdata_d[MASK_LSB +: NUM_CH]  = irq_mask_q;
      end
      SEL: begin
        readdata_d[SEL_W-1:0] = sel_q;
      end
      PERIOD: begin
        // Out-of-range SEL matches no channel and leaves the value at zero.
        for (int i = 0; i < NUM_CH; i++) begin
          readdata_d[PERIOD_W-1:0] = (sel_q == SEL_W'(i)) ? period_s[i]
                                                          : readdata_d[PERIOD_W-1:0];
        end
      end
      TICKCNT: begin
        readdata_d = tick_cnt_q;
      end
      default: begin
        readdata_d = 16'h0000;
      end
    endcase
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q     <= 1'b0;
      tick_cnt_q <= 16'h0000;
      ch_en_q    <= {NUM_CH{1'b0}};
      irq_mask_q <= {NUM_CH{1'b0}};
      sel_q      <= 3'd0;
      readdata_q <= 16'h0000;
    end else begin
      tick_q     <= tick_in;
      tick_cnt_q <= tick_cnt_d;
      ch_en_q    <= ch_en_d;
      irq_mask_q <= irq_mask_d;
      sel_q      <= sel_d;
      readdata_q <= readdata_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign load_s[g] = wr_period_s & (sel_q == SEL_W'(g));

      com_sched_channel #(
        .PERIOD_W (PERIOD_W)
      ) u_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_evt  (tick_evt_s),
        .en        (ch_en_q[g]),
        .load      (load_s[g]),
        .wdata     (writedata[PERIOD_W-1:0]),
        .clr_pend  (clr_pend_s[g]),
        .clr_ovr   (clr_ovr_s[g]),
        .due_pulse (due_s[g]),
        .pending   (pending_s[g]),
        .overrun   (overrun_s[g]),
        .period    (period_s[g])
      );
    end
  endgenerate

  assign readdata  = readdata_q;
  assign due_pulse = due_s;
  assign irq       = |(pending_s & irq_mask_q);

endmodule

// File: tb/tb_com_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_com_tick_scheduler
// Scoreboard bench: read and pulse expectations are queued by the stimulus
// and consumed by an independent monitor whenever the DUT presents read data
// or a due pulse.
// -----------------------------------------------------------------------------
module tb_com_tick_scheduler;
  import com_sched_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 8;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        tick_in    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [15:0] writedata  = 16'h0000;
  logic [15:0] readdata;
  logic [3:0]  due_pulse;
  logic        irq;

  com_tick_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_in    (tick_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .due_pulse  (due_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] val; string name; } rd_exp_t;
  typedef struct { logic [3:0] mask; int at_tick; } pulse_exp_t;

  rd_exp_t    rd_q[$];
  pulse_exp_t pulse_q[$];
  rd_exp_t    rd_e;
  pulse_exp_t pl_e;

  int total = 0;
  int bad   = 0;
  int tick_n = 0;
  int tick_total = 0;
  bit rd_req = 1'b0;
  bit rd_vld = 1'b0;

  function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endfunction

  // Read data is valid one cycle after the address is presented.
  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: consume expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_underflow: got 0x%04h expected no read", readdata);
      end else begin
        rd_e = rd_q.pop_front();
        check16(rd_e.name, readdata, rd_e.val);
      end
    end
    if (due_pulse != 4'b0000) begin
      if (pulse_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got mask 0x%01h at tick %0d expected none", due_pulse, tick_n);
      end else begin
        pl_e = pulse_q.pop_front();
        check16("pulse_mask", {12'h000, due_pulse}, {12'h000, pl_e.mask});
        check16("pulse_tick", 16'(tick_n), 16'(pl_e.at_tick));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    step();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    rd_q.push_back('{e, nm});
    address = a; chipselect = 1'b1; rd_req = 1'b1;
    step();
    chipselect = 1'b0; rd_req = 1'b0;
    step();
  endtask

  task automatic tick(input logic [3:0] m);
    tick_in = 1'b1; tick_n++; tick_total++;
    if (m != 4'b0000) pulse_q.push_back('{m, tick_n});
    step();
    tick_in = 1'b0;
    step();
  endtask

  // Tick and register write land on the same clock edge.
  task automatic tick_wr(input logic [2:0] a, input logic [15:0] d, input logic [3:0] m);
    tick_in = 1'b1; tick_n++; tick_total++;
    if (m != 4'b0000) pulse_q.push_back('{m, tick_n});
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    step();
  endtask

  task automatic chk_irq(input logic e, input string nm);
    @(negedge clk);
    check16(nm, {15'h0000, irq}, {15'h0000, e});
  endtask

  task automatic drained(input string nm);
    @(negedge clk);
    check16(nm, 16'(pulse_q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Reset state
    rd(STATUS,  16'h0000, "rst_status");
    rd(CONTROL, 16'h0000, "rst_control");
    rd(TICKCNT, 16'h0000, "rst_tickcnt");
    rd(PERIOD,  16'h0000, "rst_period");
    chk_irq(1'b0, "rst_irq");

    // 1. Basic period 2 -> fires on ticks 3, 6, 9
    wr(SEL, 16'h0000);
    wr(PERIOD, 16'h0002);
    wr(CONTROL, 16'h0101);
    tick_n = 0;
    for (int i = 1; i <= 9; i++) tick((i % 3 == 0) ? 4'b0001 : 4'b0000);
    chk_irq(1'b1, "t1_irq_set");
    rd(STATUS, 16'h0101, "t1_status");
    wr(STATUS, 16'h0001);
    chk_irq(1'b0, "t1_irq_clr");
    rd(STATUS, 16'h0100, "t1_status_ovr");
    wr(STATUS, 16'h0100);
    rd(STATUS, 16'h0000, "t1_status_clr");
    rd(TICKCNT, 16'(tick_total), "t1_tickcnt");

    // 2. Overrun with period 0 on channel 1
    wr(SEL, 16'h0001);
    wr(PERIOD, 16'h0000);
    wr(CONTROL, 16'h0202);
    tick_n = 0;
    tick(4'b0010);
    tick(4'b0010);
    rd(STATUS, 16'h0202, "t2_overrun");
    chk_irq(1'b1, "t2_irq");
    wr(STATUS, 16'h0202);
    rd(STATUS, 16'h0000, "t2_cleared");
    chk_irq(1'b0, "t2_irq_clr");

    // 3. Clear/fire races
    tick_n = 0;
    tick(4'b0010);
    tick_wr(STATUS, 16'h0002, 4'b0010);
    rd(STATUS, 16'h0002, "t3_fire_beats_clr");
    tick(4'b0010);
    rd(STATUS, 16'h0202, "t3_ovr_set");
    tick_wr(STATUS, 16'h0200, 4'b0010);
    rd(STATUS, 16'h0202, "t3_ovr_set_wins");
    wr(STATUS, 16'h0202);
    rd(STATUS, 16'h0000, "t3_cleared");
    wr(CONTROL, 16'h0000);

    // 4. Held level counts once; PERIOD write on a tick edge suppresses that tick
    tick_in = 1'b1; tick_total++;
    repeat (10) step();
    tick_in = 1'b0;
    step();
    rd(TICKCNT, 16'(tick_total), "t4_held_tick");
    wr(SEL, 16'h0000);
    wr(CONTROL, 16'h0001);
    tick_wr(PERIOD, 16'h0003, 4'b0000);
    tick_n = 0;
    tick(4'b0000); tick(4'b0000); tick(4'b0000); tick(4'b0001);
    rd(PERIOD, 16'h0003, "t4_period");

    // 5. Disable freezes, re-enable reloads
    tick(4'b0000);
    wr(CONTROL, 16'h0000);
    tick(4'b0000); tick(4'b0000); tick(4'b0000);
    wr(CONTROL, 16'h0001);
    tick_n = 0;
    tick(4'b0000); tick(4'b0000); tick(4'b0000); tick(4'b0001);
    wr(SEL, 16'h0005);
    rd(SEL, 16'h0005, "t5_sel");
    rd(PERIOD, 16'h0000, "t5_sel5_period");
    wr(PERIOD, 16'h00AA);
    wr(SEL, 16'h0001);
    rd(PERIOD, 16'h0000, "t5_ch1_untouched");
    wr(SEL, 16'h0000);
    rd(PERIOD, 16'h0003, "t5_ch0_untouched");
    drained("t5_pulses_drained");

    // 6. Async reset mid-count
    wr(CONTROL, 16'h0101);
    chk_irq(1'b1, "t6_irq_before");
    rd(CONTROL, 16'h0101, "t6_control");
    tick(4'b0000); tick(4'b0000);
    #3 reset_n = 1'b0;
    #1;
    check16("t6_rst_readdata", readdata, 16'h0000);
    check16("t6_rst_irq", {15'h0000, irq}, 16'h0000);
    check16("t6_rst_pulse", {12'h000, due_pulse}, 16'h0000);
    tick_total = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    rd(TICKCNT, 16'h0000, "t6_tickcnt_zero");
    rd(STATUS,  16'h0000, "t6_status_zero");
    rd(CONTROL, 16'h0000, "t6_control_zero");
    tick_n = 0;
    for (int i = 0; i < 5; i++) tick(4'b0000);
    rd(TICKCNT, 16'(tick_total), "t6_tickcnt_after");
    drained("t6_pulses_drained");
    check16("rd_drained", 16'(rd_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
